// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch stage placed directly upstream of instruction_mem. It owns
// the fetch PC, drives the word-aligned instruction memory address, captures
// the combinationally-read instruction word together with its PC into a small
// FIFO, and hands entries to decode over a valid/ready handshake. Redirects
// from branch/jump resolution flush every queued entry and reload the PC.
//
// Optional feature (macro IF_MISALIGN_TRAP_EN):
//   defined   - a redirect to a non-word-aligned target sets the sticky
//               fetch_misaligned flag and halts fetch until reset or a later
//               aligned redirect.
//   undefined - the low two target bits are dropped; fetch_misaligned = 0.
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     queue entries (power of two, >= 2)
//
// Ports:
//   clk               system clock, all state updates on the rising edge
//   reset             synchronous, active-high reset
//   fetch_en          1 = fetch may advance; 0 = no pushes, queue still drains
//   imem_addr         word-aligned byte address to instruction_mem
//   imem_instr        instruction word read combinationally from imem_addr
//   redirect_valid    single-cycle redirect request
//   redirect_pc       redirect target byte address
//   if_valid          head entry valid
//   if_ready          decode accepts the head entry this cycle
//   if_instr          head instruction word (0 when empty)
//   if_pc             PC of the head instruction (0 when empty)
//   fetch_misaligned  sticky misaligned-target flag
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_misaligned
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      r_pc_f;
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_halted;
    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_redirect_target;

    // Fetch is always word granular; the low target bits never reach pc_f.
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign imem_addr         = r_pc_f & 32'hFFFF_FFFC;

    assign if_valid = (r_count != '0);
    assign if_instr = if_valid ? r_q_instr[r_rd_ptr] : 32'h0;
    assign if_pc    = if_valid ? r_q_pc[r_rd_ptr]    : 32'h0;

    assign w_pop  = if_valid & if_ready;
    // A simultaneous pop frees a slot, so a full queue can still push.
    assign w_push = fetch_en & ~redirect_valid & ((r_count < FULL_COUNT) | w_pop) & ~w_halted;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_misaligned;

    // The flag doubles as the halt: both set and clear on the same events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            r_misaligned <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_halted         = r_misaligned;
    assign fetch_misaligned = r_misaligned;
`else
    assign w_halted         = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f   <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any pop/push decoded in the same cycle.
            r_pc_f   <= w_redirect_target;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_pc_f   <= r_pc_f + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; an entry is only observable once
    // count covers it, and count is reset, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_pc_f;
            r_q_instr[r_wr_ptr] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Self-checking bench for if_prefetch_queue. A queue-based reference model
// tracks the fetch PC and the in-flight {pc, instr} entries; a compare process
// checks every DUT output against it on each falling edge. Directed phases
// with literal expectations pin the model, then a randomized phase stresses
// backpressure, redirects (aligned, misaligned, near the wrap point) and
// resets. A second instance with RESET_PC = 0xFFFF_FFF8 covers PC wrap.
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_misaligned;

    // Wrap-test instance signals.
    logic        w_fetch_en;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_instr;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_if_valid;
    logic        w_if_ready;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic        w_fetch_misaligned;

    logic [31:0] mem [64];

    int n_vec = 0;
    int n_err = 0;

    if_prefetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    if_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_en(w_fetch_en),
        .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .if_valid(w_if_valid), .if_ready(w_if_ready),
        .if_instr(w_if_instr), .if_pc(w_if_pc),
        .fetch_misaligned(w_fetch_misaligned)
    );

    // Instruction memory: 64 words, ADDI x1, x0, i at word i.
    assign imem_instr   = mem[imem_addr[7:2]];
    assign w_imem_instr = mem[w_imem_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return mem[addr[7:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of {pc, instr} entries plus the fetch PC.
    // ------------------------------------------------------------------
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_mis;
    bit          m_init = 0;
    bit          m_pop;
    bit          m_push;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_mis  = 1'b0;
            m_init = 1;
        end else if (m_init) begin
            m_pop  = (m_q.size() != 0) && if_ready;
            m_push = fetch_en && !redirect_valid && ((m_q.size() < DEPTH) || m_pop) && !m_mis;
            if (redirect_valid) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
`ifdef IF_MISALIGN_TRAP_EN
                m_mis = (redirect_pc[1:0] != 2'b00);
`endif
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    m_q.push_back({m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare process: every output, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            check("if_valid", {31'b0, if_valid}, {31'b0, (m_q.size() != 0)});
            check("if_pc", if_pc, (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
            check("if_instr", if_instr, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0);
            check("imem_addr", imem_addr, m_pc);
            check("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0093 | (32'(i) << 20);

        reset            = 1'b1;
        fetch_en         = 1'b1;
        if_ready         = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        w_fetch_en       = 1'b1;
        w_if_ready       = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;
        tick();
        tick();

        // Reset sequencing and PC wrap.
        reset = 1'b0;
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
        tick();
        check("seq0_valid", {31'b0, if_valid}, 32'h1);
        check("seq0_pc", if_pc, 32'h0);
        check("seq0_instr", if_instr, 32'h0000_0093);
        check("wrap0_pc", w_if_pc, 32'hFFFF_FFF8);
        tick();
        check("seq1_pc", if_pc, 32'h4);
        check("wrap1_pc", w_if_pc, 32'hFFFF_FFFC);
        tick();
        check("seq2_pc", if_pc, 32'h8);
        check("seq2_instr", if_instr, 32'h0020_0093);
        check("wrap2_pc", w_if_pc, 32'h0000_0000);
        repeat (5) tick();
        check("seq7_pc", if_pc, 32'h1C);
        check("seq7_instr", if_instr, 32'h0070_0093);

        // Backpressure from a clean queue at PC 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        check("bp_addr", imem_addr, 32'h10);
        check("bp_pc", if_pc, 32'h0);
        check("bp_valid", {31'b0, if_valid}, 32'h1);
        if_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("drain_pc", if_pc, 32'(4 * k));
        end

        // Redirect on a full queue with a coincident pop.
        if_ready = 1'b0;
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        if_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("flush_valid", {31'b0, if_valid}, 32'h0);
        tick();
        check("tgt_pc", if_pc, 32'h40);
        check("tgt_instr", if_instr, 32'h0100_0093);
        tick();
        check("tgt_next_pc", if_pc, 32'h44);

        // Misaligned target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            check("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
            check("mis_halt_valid", {31'b0, if_valid}, 32'h0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check("mis_clear", {31'b0, fetch_misaligned}, 32'h0);
        check("mis_clear_valid", {31'b0, if_valid}, 32'h0);
        tick();
        check("mis_recover_pc", if_pc, 32'h10);
`else
        tick();
        check("mis_drop_pc", if_pc, 32'h40);
        check("mis_flag_zero", {31'b0, fetch_misaligned}, 32'h0);
`endif

        // Reset mid-stream with three queued entries and a competing redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        if_ready       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        check("mid_pc_head", if_pc, 32'h20);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        check("mid_rst_valid", {31'b0, if_valid}, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        tick();
        check("mid_rst_pc", if_pc, 32'h0);

        // Randomized phase against the model.
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(99) == 0);
            fetch_en       = ($urandom_range(9) < 8);
            if_ready       = ($urandom_range(9) < 6);
            redirect_valid = ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
            else                        redirect_pc = 32'($urandom_range(255));
            tick();
        end

        reset          = 1'b0;
        redirect_valid = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
